// File: rtl/bcd_to_binary_seq_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
// Contents: minus-sign nibble code, output mode codes, FSM state type and
// a digit classifier used by the nibble scanner.
package bcd_to_binary_seq_pkg;

  localparam logic [3:0] BCD_MINUS = 4'hE;

  localparam logic MODE_SM   = 1'b0;
  localparam logic MODE_TWOS = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic is_digit(input logic [3:0] nib);
    return nib <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_to_binary_seq_if.sv
// Handshake bundle between a BCD producer and the converter.
// Input side: in_valid/in_ready with bcd_in and mode_twos.
// Output side: out_valid/out_ready with bin_out, err and ovf.
interface bcd_to_binary_seq_if #(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  mode_twos;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_W-1:0]      bin_out;
  logic                  err;
  logic                  ovf;

  modport master (
    output in_valid, bcd_in, mode_twos, out_ready,
    input  in_ready, out_valid, bin_out, err, ovf
  );

  modport slave (
    input  in_valid, bcd_in, mode_twos, out_ready,
    output in_ready, out_valid, bin_out, err, ovf
  );
endinterface

// File: rtl/bcd_to_binary_seq_mac.sv
// Multiply-accumulate step for one BCD digit: acc_next = acc*10 + digit.
// Ports: acc/digit in, acc_next/ovf out; purely combinational.
// Magnitudes above 2^(OUT_W-1) clamp to 2^(OUT_W-1)+1 and raise ovf.
module bcd_to_binary_seq_mac #(
  parameter int OUT_W = 8
) (
  input  logic [OUT_W+3:0] acc,
  input  logic [3:0]       digit,
  output logic [OUT_W+3:0] acc_next,
  output logic             ovf
);
  localparam int AW = OUT_W + 4;
  localparam logic [AW-1:0] HALF = AW'(1) << (OUT_W - 1);

  logic [AW-1:0] prod;

  // acc is at most HALF+1 on entry, so acc*10+9 always fits in AW bits.
  always_comb begin
    prod     = (acc << 3) + (acc << 1) + AW'(digit);
    ovf      = prod > HALF;
    acc_next = ovf ? HALF + AW'(1) : prod;
  end
endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter: scans DIGITS nibbles MSB-first,
// one per clock, nibble 4'hE is a leading minus sign.
// Ports: clk, reset_n (async active-low), io (slave side of the handshake
// bundle). Result is sign-magnitude or two's complement per conversion,
// with err (illegal nibbles) and ovf (saturated magnitude) flags.
module bcd_to_binary_seq
  import bcd_to_binary_seq_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  bcd_to_binary_seq_if.slave  io
);
  localparam int AW = OUT_W + 4;
  localparam int CW = $clog2(DIGITS);
  localparam logic [AW-1:0]    HALF    = AW'(1) << (OUT_W - 1);
  localparam logic [OUT_W-1:0] POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] NEG_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  state_t              state;
  logic [4*DIGITS-1:0] sreg;
  logic [CW-1:0]       cnt;
  logic [AW-1:0]       acc;
  logic                neg;
  logic                err_f;
  logic                ovf_f;
  logic                twos;

  logic                out_valid_q;
  logic [OUT_W-1:0]    bin_out_q;
  logic                err_q;
  logic                ovf_q;

  logic [3:0]          nib;
  logic [AW-1:0]       mac_acc;
  logic                mac_ovf;
  logic                mag_ovf;
  logic [OUT_W-1:0]    fin_bin;
  logic                fin_ovf;

  assign nib = sreg[4*DIGITS-1 -: 4];

  bcd_to_binary_seq_mac #(.OUT_W(OUT_W)) u_mac (
    .acc      (acc),
    .digit    (nib),
    .acc_next (mac_acc),
    .ovf      (mac_ovf)
  );

  // Final encoding. A negative result may reach -2^(OUT_W-1) in both
  // modes (sign-magnitude reuses 1000..0 as its most-negative code), while
  // a positive result tops out at 2^(OUT_W-1)-1.
  always_comb begin
    fin_bin = '0;
    fin_ovf = 1'b0;
    mag_ovf = ovf_f || (acc > (neg ? HALF : HALF - AW'(1)));
    if (err_f || acc == '0) begin
      fin_bin = '0;
      fin_ovf = 1'b0;
    end else if (!neg) begin
      fin_ovf = mag_ovf;
      fin_bin = mag_ovf ? POS_MAX : acc[OUT_W-1:0];
    end else if (twos != MODE_TWOS) begin
      fin_ovf = mag_ovf;
      fin_bin = (mag_ovf || acc == HALF) ? NEG_MIN : {1'b1, acc[OUT_W-2:0]};
    end else begin
      fin_ovf = mag_ovf;
      fin_bin = mag_ovf ? NEG_MIN : (~acc[OUT_W-1:0] + OUT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      sreg        <= '0;
      cnt         <= '0;
      acc         <= '0;
      neg         <= 1'b0;
      err_f       <= 1'b0;
      ovf_f       <= 1'b0;
      twos        <= 1'b0;
      out_valid_q <= 1'b0;
      bin_out_q   <= '0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid) begin
            sreg  <= io.bcd_in;
            twos  <= io.mode_twos;
            cnt   <= '0;
            acc   <= '0;
            neg   <= 1'b0;
            err_f <= 1'b0;
            ovf_f <= 1'b0;
            state <= CONV;
          end
        end
        CONV: begin
          sreg <= {sreg[4*DIGITS-5:0], 4'h0};
          // Leading zeros need no special case: 0*10+0 leaves acc at 0.
          if (!err_f) begin
            if (is_digit(nib)) begin
              acc <= mac_acc;
              if (mac_ovf) ovf_f <= 1'b1;
            end else if (nib == BCD_MINUS) begin
              // acc != 0 means a nonzero digit has already been seen.
              if (neg || acc != '0) err_f <= 1'b1;
              else                  neg   <= 1'b1;
            end else begin
              err_f <= 1'b1;
            end
          end
          if (cnt == CW'(DIGITS - 1)) state <= FIN;
          else                        cnt   <= cnt + CW'(1);
        end
        FIN: begin
          bin_out_q   <= fin_bin;
          err_q       <= err_f;
          ovf_q       <= fin_ovf;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (io.out_ready) begin
            out_valid_q <= 1'b0;
            bin_out_q   <= '0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = out_valid_q;
  assign io.bin_out   = bin_out_q;
  assign io.err       = err_q;
  assign io.ovf       = ovf_q;
endmodule
